// File: rtl/secded_dec_pipe.sv
// rtl/secded_dec_pipe.sv - two-stage SECDED(39,32) decoder with valid/ready handshake
// Error counters are built only when SECDED_ERRCNT_EN is defined; otherwise ce_cnt/ue_cnt read 0.
module secded_dec_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [38:0]      IN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      OUT,
    output logic             ce,
    output logic             ue,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ce_cnt,
    output logic [CNT_W-1:0] ue_cnt
);

    // Hamming position (1..38) that carries data bit j
    function automatic int data_pos(input int j);
        int n;
        int r;
        n = 0;
        r = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (n == j) r = pos;
                n++;
            end
        end
        return r;
    endfunction

    logic        en;
    logic        s1_valid;
    logic [38:0] s1_cw;
    logic [5:0]  s1_syn;
    logic        s1_p;
    logic [5:0]  syn_c;
    logic [38:0] fixed_c;
    logic [31:0] data_c;
    logic        ce_c;
    logic        ue_c;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        syn_c = '0;
        for (int i = 0; i < 38; i++) begin
            for (int k = 0; k < 6; k++) begin
                if ((((i + 1) >> k) & 1) != 0) syn_c[k] = syn_c[k] ^ IN[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_syn   <= '0;
            s1_p     <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cw  <= IN;
                s1_syn <= syn_c;
                s1_p   <= ^IN;
            end
        end
    end

    // Odd overall parity means a single error; syndrome 0 then points at the parity bit itself
    always_comb begin
        fixed_c = s1_cw;
        ce_c    = 1'b0;
        ue_c    = 1'b0;
        if (s1_p) begin
            if (s1_syn == 6'd0) begin
                ce_c = 1'b1;
            end else if (s1_syn <= 6'd38) begin
                ce_c = 1'b1;
                for (int i = 0; i < 38; i++) begin
                    if (s1_syn == 6'(i + 1)) fixed_c[i] = ~s1_cw[i];
                end
            end else begin
                ue_c = 1'b1;
            end
        end else if (s1_syn != 6'd0) begin
            ue_c = 1'b1;
        end
    end

    always_comb begin
        data_c = '0;
        for (int j = 0; j < 32; j++) data_c[j] = fixed_c[data_pos(j) - 1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            OUT       <= '0;
            ce        <= 1'b0;
            ue        <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                OUT <= data_c;
                ce  <= ce_c;
                ue  <= ue_c;
            end
        end
    end

`ifdef SECDED_ERRCNT_EN
    logic xfer;
    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_cnt <= '0;
            ue_cnt <= '0;
        end else if (cnt_clr) begin
            ce_cnt <= '0;
            ue_cnt <= '0;
        end else if (xfer) begin
            if (ce && ce_cnt != '1) ce_cnt <= ce_cnt + CNT_W'(1);
            if (ue && ue_cnt != '1) ue_cnt <= ue_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign ce_cnt = '0;
    assign ue_cnt = '0;
`endif

endmodule

// File: tb/tb_secded_dec_pipe.sv
// tb/tb_secded_dec_pipe.sv - scoreboard bench for secded_dec_pipe
module tb_secded_dec_pipe;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [38:0]      IN;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      OUT;
    logic             ce;
    logic             ue;
    logic             cnt_clr;
    logic [CNT_W-1:0] ce_cnt;
    logic [CNT_W-1:0] ue_cnt;

    typedef struct packed {
        logic [31:0] d;
        logic        c;
        logic        u;
    } exp_t;

    exp_t sb[$];
    exp_t exp_next;
    exp_t e;
    int   passed = 0;
    int   total  = 0;
    int   popped = 0;

    secded_dec_pipe #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .IN(IN),
        .out_valid(out_valid), .out_ready(out_ready), .OUT(OUT), .ce(ce), .ue(ue),
        .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit is_chk(input int pos);
        return pos == 1 || pos == 2 || pos == 4 || pos == 8 || pos == 16 || pos == 32;
    endfunction

    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] cw;
        int j;
        cw = '0;
        j = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if (!is_chk(pos)) begin
                cw[pos-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 6; k++) begin
            logic b;
            b = 1'b0;
            for (int pos = 1; pos <= 38; pos++) if (((pos >> k) & 1) == 1) b = b ^ cw[pos-1];
            cw[(1 << k) - 1] = b;
        end
        cw[38] = ^cw[37:0];
        return cw;
    endfunction

    function automatic logic [31:0] extract(input logic [38:0] cw);
        logic [31:0] d;
        int j;
        d = '0;
        j = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if (!is_chk(pos)) begin
                d[j] = cw[pos-1];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] expc(input int v);
`ifdef SECDED_ERRCNT_EN
        return CNT_W'(v);
`else
        return CNT_W'(v & 0);
`endif
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) sb.push_back(exp_next);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL spurious_out OUT=%h ce=%b ue=%b expected no output", OUT, ce, ue);
                end else begin
                    e = sb.pop_front();
                    popped++;
                    total++;
                    if (OUT !== e.d) $display("FAIL sb_data got=%h exp=%h", OUT, e.d);
                    else passed++;
                    total++;
                    if (ce !== e.c) $display("FAIL sb_ce data=%h got=%b exp=%b", e.d, ce, e.c);
                    else passed++;
                    total++;
                    if (ue !== e.u) $display("FAIL sb_ue data=%h got=%b exp=%b", e.d, ue, e.u);
                    else passed++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [38:0] cw, input logic [31:0] d, input logic c, input logic u);
        int n;
        n = 0;
        IN = cw;
        exp_next.d = d;
        exp_next.c = c;
        exp_next.u = u;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL send_timeout in_ready=%b exp=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (sb.size() != 0) $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        IN = encode(32'd5);
        out_ready = 1'b0;
        tick();
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (OUT !== 32'h0) $display("FAIL rst_out got=%h exp=0", OUT); else passed++;
        total++; if (ce !== 1'b0 || ue !== 1'b0) $display("FAIL rst_flags got=%b%b exp=00", ce, ue); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else passed++;
        total++; if (ce_cnt !== 0 || ue_cnt !== 0) $display("FAIL rst_cnt got=%0d/%0d exp=0/0", ce_cnt, ue_cnt); else passed++;
        in_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) $display("FAIL rst_ignored cyc=%0d out_valid=%b exp=0", i, out_valid);
            else passed++;
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        send(39'h0, 32'h0, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b0) $display("FAIL lat_early out_valid=%b exp=0", out_valid); else passed++;
        tick();
        total++; if (out_valid !== 1'b1) $display("FAIL lat_out_valid got=%b exp=1", out_valid); else passed++;
        total++; if (OUT !== 32'h0 || ce !== 1'b0 || ue !== 1'b0)
            $display("FAIL lat_word got=%h ce=%b ue=%b exp=0/0/0", OUT, ce, ue); else passed++;
        drain();
    endtask

    task automatic test_single();
        send(39'h40_0000_0007, 32'h1, 1'b0, 1'b0);
        send(39'h40_0000_0003, 32'h1, 1'b1, 1'b0);
        drain();
        total++; if (ce_cnt !== expc(1)) $display("FAIL single_ce_cnt got=%0d exp=%0d", ce_cnt, expc(1)); else passed++;
        total++; if (ue_cnt !== expc(0)) $display("FAIL single_ue_cnt got=%0d exp=%0d", ue_cnt, expc(0)); else passed++;
    endtask

    task automatic test_parity_double();
        logic [38:0] cw;
        send(39'h00_0000_0007, 32'h1, 1'b1, 1'b0);
        send(39'h40_0000_0001, 32'h0, 1'b0, 1'b1);
        cw = 39'h1 << 37;
        send(cw, 32'h0, 1'b1, 1'b0);
        cw = (39'h1 << 38) | (39'h1 << 31) | (39'h1 << 6);
        send(cw, 32'h8, 1'b0, 1'b1);
        drain();
        total++; if (ce_cnt !== expc(3)) $display("FAIL pd_ce_cnt got=%0d exp=%0d", ce_cnt, expc(3)); else passed++;
        total++; if (ue_cnt !== expc(2)) $display("FAIL pd_ue_cnt got=%0d exp=%0d", ue_cnt, expc(2)); else passed++;
    endtask

    task automatic test_back_to_back();
        int idx;
        int p0;
        logic [31:0] held;
        idx = 0;
        p0 = popped;
        held = '0;
        for (int c = 0; c < 40 && (idx < 10 || sb.size() != 0); c++) begin
            out_ready = !(c >= 3 && c <= 5);
            if (idx < 10) begin
                IN = encode(32'(idx));
                exp_next.d = 32'(idx);
                exp_next.c = 1'b0;
                exp_next.u = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 3) held = OUT;
            if (c >= 3 && c <= 5) begin
                total++;
                if (in_ready !== 1'b0) $display("FAIL b2b_in_ready cyc=%0d got=%b exp=0", c, in_ready);
                else passed++;
            end
            if (c == 4 || c == 5) begin
                total++;
                if (OUT !== held || out_valid !== 1'b1)
                    $display("FAIL b2b_hold cyc=%0d got=%h/%b exp=%h/1", c, OUT, out_valid, held);
                else passed++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++;
        if (popped - p0 != 10 || sb.size() != 0)
            $display("FAIL b2b_count got=%0d pending=%0d exp=10/0", popped - p0, sb.size());
        else passed++;
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(encode(32'(i)) ^ (39'h1 << (i % 38)), 32'(i), 1'b1, 1'b0);
        drain();
        total++; if (ce_cnt !== expc(15)) $display("FAIL sat_ce_cnt got=%0d exp=%0d", ce_cnt, expc(15)); else passed++;
        total++; if (ue_cnt !== expc(2)) $display("FAIL sat_ue_cnt got=%0d exp=%0d", ue_cnt, expc(2)); else passed++;
        out_ready = 1'b0;
        send(encode(32'd7) ^ (39'h1 << 5), 32'd7, 1'b1, 1'b0);
        tick();
        total++; if (out_valid !== 1'b1) $display("FAIL clr_setup out_valid=%b exp=1", out_valid); else passed++;
        cnt_clr = 1'b1;
        out_ready = 1'b1;
        tick();
        cnt_clr = 1'b0;
        total++; if (ce_cnt !== 0 || ue_cnt !== 0) $display("FAIL clr_prio got=%0d/%0d exp=0/0", ce_cnt, ue_cnt); else passed++;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        send(encode(32'd9) ^ (39'h1 << 12), 32'd9, 1'b1, 1'b0);
        drain();
        total++; if (ce_cnt !== expc(1)) $display("FAIL mid_pre_cnt got=%0d exp=%0d", ce_cnt, expc(1)); else passed++;
        out_ready = 1'b0;
        send(encode(32'd3) ^ (39'h1 << 20), 32'd3, 1'b1, 1'b0);
        send(encode(32'd4), 32'd4, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b1) $display("FAIL mid_inflight out_valid=%b exp=1", out_valid); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_async out_valid=%b exp=0", out_valid); else passed++;
        total++; if (ce_cnt !== 0 || OUT !== 32'h0 || ce !== 1'b0)
            $display("FAIL mid_clear got=%0d/%h/%b exp=0/0/0", ce_cnt, OUT, ce); else passed++;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) $display("FAIL mid_stale cyc=%0d out_valid=%b exp=0", i, out_valid);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [38:0] cw;
        int b1;
        int b2;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            b1 = $urandom_range(0, 38);
            send(encode(d) ^ (39'h1 << b1), d, 1'b1, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            b1 = $urandom_range(0, 38);
            b2 = (b1 + $urandom_range(1, 38)) % 39;
            cw = encode(d) ^ (39'h1 << b1) ^ (39'h1 << b2);
            send(cw, extract(cw), 1'b0, 1'b1);
        end
        drain();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        IN = '0;
        out_ready = 1'b0;
        cnt_clr = 1'b0;
        exp_next = '0;
        test_reset();
        test_latency();
        test_single();
        test_parity_double();
        test_back_to_back();
        test_saturate();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog passed=%0d total=%0d", passed, total);
        $fatal(1);
    end
endmodule
